// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with PC-relative target and bubble-collapsing stages.
// Optional CSR zimm output enabled by defining IMM_GEN_CSR_ZIMM_EN.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [31:0]     Instruction,
  input  logic [XLEN-1:0] PC,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Imm,
  output logic [2:0]      ImmType,
  output logic            Illegal,
  output logic [XLEN-1:0] Target,
  output logic            TargetValid
`ifdef IMM_GEN_CSR_ZIMM_EN
  ,
  output logic [XLEN-1:0] CsrZImm
`endif
);

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_I     = 3'd1;
  localparam logic [2:0] T_S     = 3'd2;
  localparam logic [2:0] T_B     = 3'd3;
  localparam logic [2:0] T_U     = 3'd4;
  localparam logic [2:0] T_J     = 3'd5;
  localparam logic [2:0] T_SHAMT = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt;
    logic [2:0]      ityp;
    logic            ill;
    logic            tv;
`ifdef IMM_GEN_CSR_ZIMM_EN
    logic [XLEN-1:0] zimm;
`endif
  } slot_t;

  logic [6:0]        op;
  logic [2:0]        f3;
  logic              srai_fn;
  logic [XLEN-1:0]   shamt;
  logic signed [11:0] i12;
  logic signed [11:0] s12;
  logic signed [12:0] b13;
  logic signed [20:0] j21;
  logic signed [31:0] u32;
  logic              is_i;
  logic              is_sh;
  logic              is_s;
  logic              is_b;
  logic              is_j;
  logic              is_u;
  slot_t             dec;

  assign op  = Instruction[6:0];
  assign f3  = Instruction[14:12];
  assign i12 = Instruction[31:20];
  assign s12 = {Instruction[31:25], Instruction[11:7]};
  assign b13 = {Instruction[31], Instruction[7],
                Instruction[30:25], Instruction[11:8], 1'b0};
  assign j21 = {Instruction[31], Instruction[19:12],
                Instruction[20], Instruction[30:21], 1'b0};
  assign u32 = {Instruction[31:12], 12'h000};

  // shamt field widens by one bit on RV64
  generate
    if (XLEN == 64) begin : g_sh64
      assign srai_fn = (Instruction[31:26] == 6'b010000);
      assign shamt   = XLEN'(Instruction[25:20]);
    end else begin : g_sh32
      assign srai_fn = (Instruction[31:25] == 7'b0100000);
      assign shamt   = XLEN'(Instruction[24:20]);
    end
  endgenerate

  assign is_sh = (op == 7'b0010011) && (f3 == 3'b101) && srai_fn;
  assign is_i  = !is_sh && ((op == 7'b1110011) || (op == 7'b0000011) ||
                            (op == 7'b0010011) || (op == 7'b1100111) ||
                            (op == 7'b0000001));
  assign is_s  = (op == 7'b0100011);
  assign is_b  = (op == 7'b1100011);
  assign is_j  = (op == 7'b1101111);
  assign is_u  = (op == 7'b0110111) || (op == 7'b0010111);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      is_sh: begin
        dec.imm  = shamt;
        dec.ityp = T_SHAMT;
      end
      is_i: begin
        dec.imm  = XLEN'(i12);
        dec.ityp = T_I;
      end
      is_s: begin
        dec.imm  = XLEN'(s12);
        dec.ityp = T_S;
      end
      is_b: begin
        dec.imm  = XLEN'(b13);
        dec.ityp = T_B;
        dec.tv   = 1'b1;
      end
      is_j: begin
        dec.imm  = XLEN'(j21);
        dec.ityp = T_J;
        dec.tv   = 1'b1;
      end
      is_u: begin
        dec.imm  = XLEN'(u32);
        dec.ityp = T_U;
        dec.tv   = (op == 7'b0010111);
      end
      default: begin
        dec.ityp = T_NONE;
        dec.ill  = 1'b1;
      end
    endcase
    dec.tgt = PC + dec.imm;
`ifdef IMM_GEN_CSR_ZIMM_EN
    if ((op == 7'b1110011) && f3[2])
      dec.zimm = XLEN'(Instruction[19:15]);
`endif
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  slot_t             pay [STAGES];

  // a slot may load when it, or any slot downstream, frees up this cycle
  always_comb begin
    logic c;
    ld = '0;
    c  = OutReady;
    for (int i = STAGES - 1; i >= 0; i--) begin
      c     = !vld[i] || c;
      ld[i] = c;
    end
  end

  assign InReady = ld[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      if (ld[0])
        vld[0] <= InValid;
      for (int i = 1; i < STAGES; i++)
        if (ld[i])
          vld[i] <= vld[i-1];
      if (Flush)
        vld <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++)
        pay[i] <= '0;
    end else begin
      if (ld[0] && InValid)
        pay[0] <= dec;
      for (int i = 1; i < STAGES; i++)
        if (ld[i] && vld[i-1])
          pay[i] <= pay[i-1];
    end
  end

  assign OutValid    = vld[STAGES-1];
  assign Imm         = pay[STAGES-1].imm;
  assign Target      = pay[STAGES-1].tgt;
  assign ImmType     = pay[STAGES-1].ityp;
  assign Illegal     = pay[STAGES-1].ill;
  assign TargetValid = pay[STAGES-1].tv;
`ifdef IMM_GEN_CSR_ZIMM_EN
  assign CsrZImm     = pay[STAGES-1].zimm;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized bench for imm_gen_pipe: 2-stage RV32 instance under handshake
// plus a 1-stage RV64 instance, both checked against a decode/queue model.
module tb_imm_gen_pipe;

  localparam int ST = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Imm;
  logic [2:0]  ImmType;
  logic        Illegal;
  logic [31:0] Target;
  logic        TargetValid;
  logic [63:0] PC64;
  logic        InReady64;
  logic        OutValid64;
  logic [63:0] Imm64;
  logic [2:0]  ImmType64;
  logic        Illegal64;
  logic [63:0] Target64;
  logic        TargetValid64;
`ifdef IMM_GEN_CSR_ZIMM_EN
  logic [31:0] CsrZImm;
  logic [63:0] CsrZImm64;
`endif

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .Instruction(Instruction), .PC(PC),
    .OutValid(OutValid), .OutReady(OutReady),
    .Imm(Imm), .ImmType(ImmType), .Illegal(Illegal),
    .Target(Target), .TargetValid(TargetValid)
`ifdef IMM_GEN_CSR_ZIMM_EN
    , .CsrZImm(CsrZImm)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .STAGES(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .Flush(Flush),
    .InValid(InValid), .InReady(InReady64),
    .Instruction(Instruction), .PC(PC64),
    .OutValid(OutValid64), .OutReady(1'b1),
    .Imm(Imm64), .ImmType(ImmType64), .Illegal(Illegal64),
    .Target(Target64), .TargetValid(TargetValid64)
`ifdef IMM_GEN_CSR_ZIMM_EN
    , .CsrZImm(CsrZImm64)
`endif
  );

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [63:0] z;
    logic [2:0]  t;
    logic        ill;
    logic        tv;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t e64;
  bit   v64_pend = 0;
  bit   last_ov;
  logic [31:0] so_imm, so_tgt;
  logic [4:0]  so_meta;
  logic [63:0] so64_imm;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Straight from the decode table; XLEN=32 results are the low word.
  function automatic exp_t model(input logic [31:0] ins,
                                 input logic [63:0] pc, input bit w64);
    exp_t r;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    longint imm = 0;
    bit sr;
    r.t = 0; r.ill = 0; r.tv = 0; r.z = 0;
    sr = w64 ? (ins[31:26] == 6'b010000) : (ins[31:25] == 7'b0100000);
    if (op == 7'h13 && f3 == 3'd5 && sr) begin
      imm = w64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
      r.t = 6;
    end else if (op inside {7'h73, 7'h03, 7'h13, 7'h67, 7'h01}) begin
      imm = $signed(ins[31:20]);
      r.t = 1;
    end else if (op == 7'h23) begin
      imm = $signed({ins[31:25], ins[11:7]});
      r.t = 2;
    end else if (op == 7'h63) begin
      imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      r.t = 3; r.tv = 1;
    end else if (op == 7'h6F) begin
      imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      r.t = 5; r.tv = 1;
    end else if (op == 7'h37 || op == 7'h17) begin
      imm = $signed({ins[31:12], 12'h000});
      r.t = 4; r.tv = (op == 7'h17);
    end else begin
      r.ill = 1;
    end
    if (op == 7'h73 && f3[2]) r.z = 64'(ins[19:15]);
    r.imm = imm;
    r.tgt = pc + r.imm;
    if (!w64) begin
      r.imm = {32'h0, r.imm[31:0]};
      r.tgt = {32'h0, r.tgt[31:0]};
    end
    return r;
  endfunction

  // One clock: check outputs at negedge, update model, advance past posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    chk("inready", InReady, OutReady || (q.size() < ST));
    last_ov = OutValid;
    if (OutValid) begin
      so_imm  = Imm;
      so_tgt  = Target;
      so_meta = {ImmType, Illegal, TargetValid};
      if (q.size() == 0) begin
        chk("spurious_ov", OutValid, 1'b0);
      end else begin
        e = q[0];
        chk("imm", Imm, e.imm[31:0]);
        chk("target", Target, e.tgt[31:0]);
        chk("meta", {ImmType, Illegal, TargetValid}, {e.t, e.ill, e.tv});
`ifdef IMM_GEN_CSR_ZIMM_EN
        chk("zimm", CsrZImm, e.z[31:0]);
`endif
        if (OutReady) void'(q.pop_front());
      end
    end
    chk("ov64", OutValid64, v64_pend);
    if (v64_pend && OutValid64) begin
      so64_imm = Imm64;
      chk("imm64", Imm64, e64.imm);
      chk("target64", Target64, e64.tgt);
      chk("meta64", {ImmType64, Illegal64, TargetValid64},
          {e64.t, e64.ill, e64.tv});
`ifdef IMM_GEN_CSR_ZIMM_EN
      chk("zimm64", CsrZImm64, e64.z);
`endif
    end
    if (InValid && InReady && !Flush)
      q.push_back(model(Instruction, {32'h0, PC}, 1'b0));
    v64_pend = InValid && !Flush;
    e64 = model(Instruction, PC64, 1'b1);
    if (Flush) q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    Instruction = ins;
    PC          = pc;
    PC64        = {pc, pc};
  endtask

  task automatic send1(input string tag, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [31:0] ximm,
                       input logic [31:0] xtgt, input logic [4:0] xmeta);
    int lat = 0;
    OutReady = 1; Flush = 0; InValid = 1;
    drive(ins, pc);
    step();
    InValid = 0;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (last_ov) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, lat, ST);
    chk({tag, "_imm"}, so_imm, ximm);
    chk({tag, "_tgt"}, so_tgt, xtgt);
    chk({tag, "_meta"}, so_meta, xmeta);
  endtask

  logic [6:0] ops [13] = '{7'h73, 7'h03, 7'h13, 7'h67, 7'h01, 7'h23,
                           7'h63, 7'h6F, 7'h37, 7'h17, 7'h13, 7'h7F, 7'h33};

  initial begin
    rst_n = 0; Flush = 0; InValid = 0; OutReady = 0;
    drive(32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", OutValid, 1'b0);
    chk("rst_imm", Imm, 32'h0);
    chk("rst_tgt", Target, 32'h0);
    chk("rst_meta", {ImmType, Illegal, TargetValid}, 5'h0);
    rst_n = 1;
    #1;
    chk("rst_rdy", InReady, 1'b1);

    send1("addi", 32'hFFF00093, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, {3'd1, 2'b00});
    send1("srai", 32'h4030D093, 32'h0, 32'h3, 32'h3, {3'd6, 2'b00});
    chk("srai64", so64_imm, 64'h3);
    send1("jal", 32'h0080006F, 32'h100, 32'h8, 32'h108, {3'd5, 2'b01});
    send1("beq", 32'hFE000EE3, 32'h200, 32'hFFFFFFFC, 32'h1FC, {3'd3, 2'b01});
    send1("ill", 32'h0000007F, 32'h40, 32'h0, 32'h40, {3'd0, 2'b10});
    send1("auipc", 32'h80000017, 32'h10, 32'h80000000, 32'h80000010, {3'd4, 2'b01});
    send1("csr", 32'h305FD073, 32'h0, 32'h305, 32'h305, {3'd1, 2'b00});

    // backpressure: two accepted, third held, then back-to-back drain
    OutReady = 0; InValid = 1;
    drive(32'h00100093, 32'h4); step();
    drive(32'h00200113, 32'h8); step();
    drive(32'h00300193, 32'hC);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("full_rdy", InReady, 1'b0);
      chk("full_imm", so_imm, 32'h1);
    end
    OutReady = 1;
    step();
    InValid = 0;
    chk("drain0", so_imm, 32'h1);
    step();
    chk("drain1_ov", last_ov, 1'b1);
    chk("drain1", so_imm, 32'h2);
    step();
    chk("drain2_ov", last_ov, 1'b1);
    chk("drain2", so_imm, 32'h3);
    step();
    chk("drain_empty", last_ov, 1'b0);

    // flush with two in flight and a concurrent input
    OutReady = 0; InValid = 1;
    drive(32'h00500093, 32'h0); step();
    drive(32'h00600093, 32'h0); step();
    OutReady = 1; Flush = 1;
    drive(32'h00700093, 32'h0); step();
    Flush = 0; InValid = 0;
    chk("flush_q", q.size(), 0);
    step();
    chk("flush_ov", last_ov, 1'b0);
    repeat (3) step();

    // reset mid-stall
    OutReady = 0; InValid = 1;
    drive(32'h00800093, 32'h0); step();
    drive(32'h00900093, 32'h0); step(); step();
    InValid = 0;
    rst_n = 0;
    #1;
    chk("mrst_ov", OutValid, 1'b0);
    chk("mrst_imm", Imm, 32'h0);
    chk("mrst_tgt", Target, 32'h0);
    chk("mrst_meta", {ImmType, Illegal, TargetValid}, 5'h0);
    chk("mrst_ov64", OutValid64, 1'b0);
    chk("mrst_rdy", InReady, 1'b1);
    q.delete();
    v64_pend = 0;
    @(posedge clk);
    #1;
    rst_n = 1;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 12)];
      if ($urandom_range(0, 7) == 0) begin
        ins[6:0]   = 7'h13;
        ins[14:12] = 3'b101;
        ins[31:25] = ($urandom_range(0, 1) == 0) ? 7'h20 : 7'h00;
      end
      if ($urandom_range(0, 7) == 0) ins[6:0] = 7'($urandom);
      drive(ins, $urandom);
      InValid  = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 3) != 0);
      Flush    = ($urandom_range(0, 40) == 0);
      step();
    end

    InValid = 0; Flush = 0; OutReady = 1;
    repeat (ST + 2) step();
    chk("drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
